// File: rtl/acl2_spi_responder.sv
`default_nettype none
// ============================================================================
// acl2_spi_responder : SPI mode-0 slave emulating the accelerometer registers
// Revision: 1.0
// ============================================================================
module acl2_spi_responder (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] sample_x,
  input  logic [11:0] sample_y,
  input  logic [11:0] sample_z,
  output logic [7:0]  power_ctl,
  output logic [7:0]  filter_ctl,
  output logic        measuring,
  output logic        wr_strobe
);

  typedef enum logic [1:0] {ST_IDLE, ST_INSTR, ST_ADDR, ST_DATA} state_t;
  typedef enum logic [1:0] {MD_IGN, MD_WR, MD_RD} mode_t;

  localparam logic [7:0] c_cmd_write  = 8'h0A;
  localparam logic [7:0] c_cmd_read   = 8'h0B;
  localparam logic [7:0] c_addr_fltr  = 8'h2C;
  localparam logic [7:0] c_addr_power = 8'h2D;
  localparam logic [7:0] c_fltr_rst   = 8'h13;

  // [0] first sync stage, [1] synchronized value, [2] previous synchronized value
  logic [2:0]  r_sclk_sync;
  logic [2:0]  r_cs_sync;
  logic [1:0]  r_mosi_sync;

  state_t      r_state;
  mode_t       r_mode;
  logic [2:0]  r_cnt;
  logic [6:0]  r_rx;
  logic [7:0]  r_addr;
  logic [7:0]  r_tx;
  logic [11:0] r_snap_x;
  logic [11:0] r_snap_y;
  logic [11:0] r_snap_z;

  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_cs_rise;
  logic        w_cs_fall;
  logic [7:0]  w_byte;
  logic [7:0]  w_rd_addr;
  logic [7:0]  w_rd_data;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_sclk_sync <= 3'b000;
      r_cs_sync   <= 3'b111;
      r_mosi_sync <= 2'b00;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
      r_cs_sync   <= {r_cs_sync[1:0], CS};
      r_mosi_sync <= {r_mosi_sync[0], MOSI};
    end
  end

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
  assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
  assign w_byte      = {r_rx, r_mosi_sync[1]};

  // Next byte to present: the just-received address, or the auto-incremented one
  always_comb begin
    w_rd_addr = (r_state == ST_ADDR) ? w_byte : r_addr + 8'd1;
    case (w_rd_addr)
      8'h00:        w_rd_data = 8'hAD;
      8'h01:        w_rd_data = 8'h1D;
      8'h02:        w_rd_data = 8'hF2;
      8'h0E:        w_rd_data = r_snap_x[7:0];
      8'h0F:        w_rd_data = {{4{r_snap_x[11]}}, r_snap_x[11:8]};
      8'h10:        w_rd_data = r_snap_y[7:0];
      8'h11:        w_rd_data = {{4{r_snap_y[11]}}, r_snap_y[11:8]};
      8'h12:        w_rd_data = r_snap_z[7:0];
      8'h13:        w_rd_data = {{4{r_snap_z[11]}}, r_snap_z[11:8]};
      c_addr_fltr:  w_rd_data = filter_ctl;
      c_addr_power: w_rd_data = power_ctl;
      default:      w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_mode     <= MD_IGN;
      r_cnt      <= 3'd0;
      r_rx       <= 7'd0;
      r_addr     <= 8'd0;
      r_tx       <= 8'd0;
      r_snap_x   <= 12'd0;
      r_snap_y   <= 12'd0;
      r_snap_z   <= 12'd0;
      power_ctl  <= 8'h00;
      filter_ctl <= c_fltr_rst;
      measuring  <= 1'b0;
      wr_strobe  <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      // A CS rise outranks any simultaneous SCLK edge, so a racing 8th bit never writes
      if (w_cs_rise) begin
        r_state <= ST_IDLE;
        r_cnt   <= 3'd0;
        r_tx    <= 8'd0;
      end else if (w_cs_fall) begin
        r_state  <= ST_INSTR;
        r_mode   <= MD_IGN;
        r_cnt    <= 3'd0;
        r_tx     <= 8'd0;
        r_snap_x <= sample_x;
        r_snap_y <= sample_y;
        r_snap_z <= sample_z;
      end else if (r_state != ST_IDLE) begin
        if (w_sclk_rise) begin
          r_rx  <= w_byte[6:0];
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            case (r_state)
              ST_INSTR: begin
                if (w_byte == c_cmd_write) begin
                  r_state <= ST_ADDR;
                  r_mode  <= MD_WR;
                end else if (w_byte == c_cmd_read) begin
                  r_state <= ST_ADDR;
                  r_mode  <= MD_RD;
                end else begin
                  r_state <= ST_DATA;
                  r_mode  <= MD_IGN;
                end
              end
              ST_ADDR: begin
                r_addr  <= w_byte;
                r_state <= ST_DATA;
                if (r_mode == MD_RD) r_tx <= w_rd_data;
              end
              ST_DATA: begin
                if (r_mode == MD_WR) begin
                  wr_strobe <= 1'b1;
                  r_addr    <= r_addr + 8'd1;
                  if (r_addr == c_addr_fltr) filter_ctl <= w_byte;
                  if (r_addr == c_addr_power) begin
                    power_ctl <= w_byte;
                    measuring <= (w_byte[1:0] == 2'b10);
                  end
                end else if (r_mode == MD_RD) begin
                  r_addr <= r_addr + 8'd1;
                  r_tx   <= w_rd_data;
                end
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end else if (w_sclk_fall && r_state == ST_DATA && r_mode == MD_RD && r_cnt != 3'd0) begin
          // The fall after the 8th rise (counter already 0) must not disturb the fresh load
          r_tx <= {r_tx[6:0], 1'b0};
        end
      end
    end
  end

  assign MISO = r_tx[7] & ~CS;

endmodule
`default_nettype wire

// File: tb/tb_acl2_spi_responder.sv
`default_nettype none
// ============================================================================
// tb_acl2_spi_responder : bench for the accelerometer SPI responder
// Revision: 1.0
// ============================================================================
module tb_acl2_spi_responder;

  localparam int HALF = 6;

  logic        Clock;
  logic        Reset;
  logic        SCLK;
  logic        CS;
  logic        MOSI;
  logic        MISO;
  logic [11:0] sample_x;
  logic [11:0] sample_y;
  logic [11:0] sample_z;
  logic [7:0]  power_ctl;
  logic [7:0]  filter_ctl;
  logic        measuring;
  logic        wr_strobe;

  int total = 0;
  int bad   = 0;
  int strobe_cnt = 0;
  logic [7:0] exp_q[$];

  acl2_spi_responder dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .SCLK       (SCLK),
    .CS         (CS),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .sample_x   (sample_x),
    .sample_y   (sample_y),
    .sample_z   (sample_z),
    .power_ctl  (power_ctl),
    .filter_ctl (filter_ctl),
    .measuring  (measuring),
    .wr_strobe  (wr_strobe)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(negedge Clock) if (wr_strobe) strobe_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not end, required finish within 2ms");
    $fatal(1);
  end

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic [7:0] exp_pwr;
    logic [7:0] exp_flt;
    logic       exp_meas;
  } vec_t;

  vec_t vecs[14];

  task automatic wait_clks(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      MOSI = tx[7-i];
      wait_clks(HALF);
      rx = {rx[6:0], MISO};
      SCLK = 1'b1;
      wait_clks(HALF);
      SCLK = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp, input string name);
    logic [7:0] rx;
    logic [7:0] want;
    exp_q.push_back(exp);
    spi_bits(tx, 8, rx);
    want = exp_q.pop_front();
    check(name, {24'd0, rx}, {24'd0, want});
  endtask

  task automatic cs_begin();
    CS = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_end();
    wait_clks(HALF);
    CS = 1'b1;
    wait_clks(HALF + 4);
  endtask

  task automatic id_read(input string tag);
    cs_begin();
    xfer(8'h0B, 8'h00, {tag, "_instr"});
    xfer(8'h00, 8'h00, {tag, "_addr"});
    xfer(8'h00, 8'hAD, {tag, "_id0"});
    xfer(8'h00, 8'h1D, {tag, "_id1"});
    xfer(8'h00, 8'hF2, {tag, "_id2"});
    cs_end();
  endtask

  function automatic logic [7:0] hi_byte(input logic [11:0] s);
    return {{4{s[11]}}, s[11:8]};
  endfunction

  initial begin
    logic [7:0] dummy;
    int s0;
    vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'hAD, 8'h00, 8'h13, 1'b0};
    vecs[1]  = '{1'b0, 8'h01, 8'h00, 8'h1D, 8'h00, 8'h13, 1'b0};
    vecs[2]  = '{1'b0, 8'h02, 8'h00, 8'hF2, 8'h00, 8'h13, 1'b0};
    vecs[3]  = '{1'b0, 8'h2C, 8'h00, 8'h13, 8'h00, 8'h13, 1'b0};
    vecs[4]  = '{1'b0, 8'h2D, 8'h00, 8'h00, 8'h00, 8'h13, 1'b0};
    vecs[5]  = '{1'b1, 8'h2D, 8'h02, 8'h00, 8'h02, 8'h13, 1'b1};
    vecs[6]  = '{1'b0, 8'h2D, 8'h00, 8'h02, 8'h02, 8'h13, 1'b1};
    vecs[7]  = '{1'b1, 8'h2C, 8'h55, 8'h00, 8'h02, 8'h55, 1'b1};
    vecs[8]  = '{1'b0, 8'h2C, 8'h00, 8'h55, 8'h02, 8'h55, 1'b1};
    vecs[9]  = '{1'b1, 8'h00, 8'h77, 8'h00, 8'h02, 8'h55, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 8'hAD, 8'h02, 8'h55, 1'b1};
    vecs[11] = '{1'b0, 8'h7F, 8'h00, 8'h00, 8'h02, 8'h55, 1'b1};
    vecs[12] = '{1'b1, 8'h2D, 8'h0B, 8'h00, 8'h0B, 8'h55, 1'b0};
    vecs[13] = '{1'b1, 8'h2D, 8'h0A, 8'h00, 8'h0A, 8'h55, 1'b1};

    Reset = 1'b0; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0;
    sample_x = 12'h000; sample_y = 12'h000; sample_z = 12'h000;
    wait_clks(4);
    Reset = 1'b1;
    wait_clks(4);

    check("rst_miso", {31'd0, MISO}, 32'd0);
    check("rst_power", {24'd0, power_ctl}, 32'h00);
    check("rst_filter", {24'd0, filter_ctl}, 32'h13);
    check("rst_meas", {31'd0, measuring}, 32'd0);
    check("rst_strobe", {31'd0, wr_strobe}, 32'd0);

    id_read("id");

    for (int i = 0; i < 14; i++) begin
      s0 = strobe_cnt;
      cs_begin();
      xfer(vecs[i].wr ? 8'h0A : 8'h0B, 8'h00, $sformatf("v%0d_instr", i));
      xfer(vecs[i].addr, 8'h00, $sformatf("v%0d_addr", i));
      xfer(vecs[i].data, vecs[i].exp_rd, $sformatf("v%0d_data", i));
      cs_end();
      check($sformatf("v%0d_power", i), {24'd0, power_ctl}, {24'd0, vecs[i].exp_pwr});
      check($sformatf("v%0d_filter", i), {24'd0, filter_ctl}, {24'd0, vecs[i].exp_flt});
      check($sformatf("v%0d_meas", i), {31'd0, measuring}, {31'd0, vecs[i].exp_meas});
      check($sformatf("v%0d_strobes", i), strobe_cnt - s0, {31'd0, vecs[i].wr});
    end

    // Burst sample read, samples changed mid-burst
    sample_x = 12'h123; sample_y = 12'hFFE; sample_z = 12'h800;
    wait_clks(2);
    cs_begin();
    xfer(8'h0B, 8'h00, "burst_instr");
    xfer(8'h0E, 8'h00, "burst_addr");
    xfer(8'h00, 8'h23, "burst_x_lo");
    xfer(8'h00, 8'h01, "burst_x_hi");
    sample_x = 12'h7AB; sample_y = 12'h001; sample_z = 12'h3C4;
    xfer(8'h00, 8'hFE, "burst_y_lo");
    xfer(8'h00, 8'hFF, "burst_y_hi");
    xfer(8'h00, 8'h00, "burst_z_lo");
    xfer(8'h00, 8'hF8, "burst_z_hi");
    cs_end();

    // New transaction sees the new snapshot
    cs_begin();
    xfer(8'h0B, 8'h00, "snap2_instr");
    xfer(8'h0F, 8'h00, "snap2_addr");
    xfer(8'h00, hi_byte(12'h7AB), "snap2_x_hi");
    xfer(8'h00, 8'h01, "snap2_y_lo");
    cs_end();

    // Address wrap 0xFF -> 0x00
    cs_begin();
    xfer(8'h0B, 8'h00, "wrap_instr");
    xfer(8'hFF, 8'h00, "wrap_addr");
    xfer(8'h00, 8'h00, "wrap_ff");
    xfer(8'h00, 8'hAD, "wrap_00");
    cs_end();

    // Abort mid data byte
    s0 = strobe_cnt;
    cs_begin();
    xfer(8'h0A, 8'h00, "abort_instr");
    xfer(8'h2D, 8'h00, "abort_addr");
    spi_bits(8'hFF, 4, dummy);
    cs_end();
    check("abort_power", {24'd0, power_ctl}, 32'h0A);
    check("abort_strobes", strobe_cnt - s0, 32'd0);

    // CS rise coincident with the 8th SCLK rise
    s0 = strobe_cnt;
    cs_begin();
    xfer(8'h0A, 8'h00, "race_instr");
    xfer(8'h2D, 8'h00, "race_addr");
    spi_bits(8'h00, 7, dummy);
    MOSI = 1'b1;
    wait_clks(HALF);
    SCLK = 1'b1;
    CS = 1'b1;
    wait_clks(HALF);
    SCLK = 1'b0;
    wait_clks(HALF + 4);
    check("race_power", {24'd0, power_ctl}, 32'h0A);
    check("race_strobes", strobe_cnt - s0, 32'd0);

    // Unknown instruction
    s0 = strobe_cnt;
    cs_begin();
    xfer(8'h55, 8'h00, "unk_instr");
    xfer(8'h00, 8'h00, "unk_b1");
    xfer(8'h00, 8'h00, "unk_b2");
    cs_end();
    check("unk_power", {24'd0, power_ctl}, 32'h0A);
    check("unk_filter", {24'd0, filter_ctl}, 32'h55);
    check("unk_strobes", strobe_cnt - s0, 32'd0);
    id_read("after_unk");

    // Reset during byte 3 of a read
    cs_begin();
    xfer(8'h0B, 8'h00, "rr_instr");
    xfer(8'h00, 8'h00, "rr_addr");
    spi_bits(8'h00, 4, dummy);
    #2;
    Reset = 1'b0;
    #1;
    check("rr_miso", {31'd0, MISO}, 32'd0);
    check("rr_power", {24'd0, power_ctl}, 32'h00);
    check("rr_filter", {24'd0, filter_ctl}, 32'h13);
    check("rr_meas", {31'd0, measuring}, 32'd0);
    check("rr_strobe", {31'd0, wr_strobe}, 32'd0);
    wait_clks(2);
    CS = 1'b1;
    wait_clks(2);
    Reset = 1'b1;
    wait_clks(4);
    id_read("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
